// File: rtl/bwt_pkg.sv
// rtl/bwt_pkg.sv - shared row, state and FIFO-select types for the BWT merge sorter
package bwt_pkg;

  localparam int BWT_COLUMN = 3;
  localparam int BWT_CNT_W  = 16;

  typedef logic [BWT_COLUMN-1:0][7:0] row_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } split_state_e;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } fifo_sel_e;

endpackage

// File: rtl/bwt_run_splitter_if.sv
// rtl/bwt_run_splitter_if.sv - pass control, input FIFO read side and A/B FIFO write side of the splitter
interface bwt_run_splitter_if #(
  parameter int COLUMN = 3,
  parameter int CNT_W  = 16
);

  logic                   start;
  logic [CNT_W-1:0]       row_count;
  logic [1:0]             sort_num;
  logic [COLUMN-1:0][7:0] row_in;
  logic                   in_empty;
  logic                   rd_in;
  logic                   full_a;
  logic                   full_b;
  logic                   wr_a;
  logic                   wr_b;
  logic [COLUMN-1:0][7:0] row_out;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       run_count;

  modport master (
    output start, row_count, sort_num, row_in, in_empty, full_a, full_b,
    input  rd_in, wr_a, wr_b, row_out, busy, done, run_count
  );

  modport slave (
    input  start, row_count, sort_num, row_in, in_empty, full_a, full_b,
    output rd_in, wr_a, wr_b, row_out, busy, done, run_count
  );

endinterface

// File: rtl/bwt_key_extract.sv
// rtl/bwt_key_extract.sv - selects the sort key byte of a row; out-of-range columns yield 8'h00
module bwt_key_extract #(
  parameter int COLUMN = 3
) (
  input  logic [COLUMN-1:0][7:0] row_i,
  input  logic [1:0]             col_i,
  output logic [7:0]             key_o
);

  always_comb begin
    key_o = 8'h00;
    for (int i = 0; i < COLUMN; i++) begin
      if (int'(col_i) == i) key_o = row_i[i];
    end
  end

endmodule

// File: rtl/bwt_run_splitter.sv
// rtl/bwt_run_splitter.sv - splits the input row stream into ascending runs, alternating FIFO A and FIFO B
// Define BWT_SPLIT_STATS_EN to build the run_count counter; otherwise run_count is tied to 0.
module bwt_run_splitter
  import bwt_pkg::*;
#(
  parameter int COLUMN = BWT_COLUMN,
  parameter int CNT_W  = BWT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  bwt_run_splitter_if.slave bus
);

  split_state_e           state_q, state_d;
  logic [CNT_W-1:0]       row_count_q, row_count_d;
  logic [CNT_W-1:0]       rows_done_q, rows_done_d;
  logic [CNT_W-1:0]       rows_next;
  logic [1:0]             sort_num_q, sort_num_d;
  fifo_sel_e              sel_q, sel_d;
  logic                   first_q, first_d;
  logic [7:0]             prev_key_q, prev_key_d;
  logic [COLUMN-1:0][7:0] row_q, row_d;
  logic [7:0]             key;
  logic                   new_run;
  logic                   sel_full;
  logic                   wr_fire;
  logic                   pass_start;

  bwt_key_extract #(.COLUMN(COLUMN)) u_key (
    .row_i (bus.row_in),
    .col_i (sort_num_q),
    .key_o (key)
  );

  // first_q keeps a stale prev_key from the previous pass from splitting row 1
  assign new_run    = !first_q && (key < prev_key_q);
  assign sel_full   = (sel_q == SEL_A) ? bus.full_a : bus.full_b;
  assign wr_fire    = (state_q == S_WRITE) && !sel_full;
  assign rows_next  = rows_done_q + 1'b1;
  assign pass_start = (state_q == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_count_q <= '0;
      rows_done_q <= '0;
      sort_num_q  <= '0;
      sel_q       <= SEL_A;
      first_q     <= 1'b1;
      prev_key_q  <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      row_count_q <= row_count_d;
      rows_done_q <= rows_done_d;
      sort_num_q  <= sort_num_d;
      sel_q       <= sel_d;
      first_q     <= first_d;
      prev_key_q  <= prev_key_d;
      row_q       <= row_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_count_d = row_count_q;
    rows_done_d = rows_done_q;
    sort_num_d  = sort_num_q;
    sel_d       = sel_q;
    first_d     = first_q;
    prev_key_d  = prev_key_q;
    row_d       = row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          row_count_d = bus.row_count;
          sort_num_d  = bus.sort_num;
          rows_done_d = '0;
          sel_d       = SEL_A;
          first_d     = 1'b1;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        // an empty pass exits here so done lands two cycles after start
        if (row_count_q == '0)  state_d = S_DONE;
        else if (!bus.in_empty) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        row_d      = bus.row_in;
        first_d    = 1'b0;
        prev_key_d = key;
        if (new_run) sel_d = (sel_q == SEL_A) ? SEL_B : SEL_A;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (wr_fire) begin
          rows_done_d = rows_next;
          state_d     = (rows_next == row_count_q) ? S_DONE : S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef BWT_SPLIT_STATS_EN
  logic [CNT_W-1:0] run_count_q, run_count_d;

  always_ff @(posedge clk) begin
    if (rst) run_count_q <= '0;
    else     run_count_q <= run_count_d;
  end

  always_comb begin
    run_count_d = run_count_q;
    if (pass_start)
      run_count_d = '0;
    else if ((state_q == S_CAPTURE) && (first_q || new_run))
      run_count_d = run_count_q + 1'b1;
  end

  assign bus.run_count = run_count_q;
`else
  logic unused_pass_start;
  assign unused_pass_start = pass_start;
  assign bus.run_count     = '0;
`endif

  assign bus.rd_in   = (state_q == S_READ);
  assign bus.wr_a    = wr_fire && (sel_q == SEL_A);
  assign bus.wr_b    = wr_fire && (sel_q == SEL_B);
  assign bus.row_out = row_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bwt_run_splitter.sv
// tb/tb_bwt_run_splitter.sv - scoreboard bench for bwt_run_splitter with directed passes
module tb_bwt_run_splitter;
  import bwt_pkg::*;

  typedef struct {
    int runs;
    bit zero;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bwt_run_splitter_if #(.COLUMN(BWT_COLUMN), .CNT_W(BWT_CNT_W)) bus ();

  bwt_run_splitter #(.COLUMN(BWT_COLUMN), .CNT_W(BWT_CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  row_t      in_q[$];
  row_t      pend_q[$];
  row_t      exp_a[$];
  row_t      exp_b[$];
  done_exp_t exp_done[$];
  done_exp_t mon_de;
  row_t      mon_row;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cyc = 0, last_wr_cyc = 0, first_rd_cyc = -1, first_b_cyc = -1, a3_cyc = -1;
  int gap_fall_cyc = -1;
  int a_writes = 0, b_writes = 0, rd_cnt = 0, done_cnt = 0;
  bit gap_armed = 1'b0;
  bit prev_empty = 1'b1;

  logic [7:0] kv[8];
  bit         dv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int er(input int n);
`ifdef BWT_SPLIT_STATS_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  function automatic row_t mkrow(input logic [7:0] key, input int idx, input int col);
    row_t r;
    r[0] = 8'hC0 ^ 8'(idx);
    r[1] = 8'h30 + 8'(idx);
    r[2] = 8'h90 - 8'(idx);
    if (col < BWT_COLUMN) r[col] = key;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // input FIFO model: data appears the cycle after rd_in
  always @(posedge clk) begin
    if (bus.rd_in && !rst && in_q.size() > 0) bus.row_in <= in_q.pop_front();
  end

  always begin
    @(posedge clk);
    #2;
    bus.in_empty = (in_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_a || bus.wr_b) begin
        check("wr_onehot", 32'(bus.wr_a & bus.wr_b), 0);
        last_wr_cyc = cyc;
      end
      if (bus.wr_a) begin
        a_writes++;
        if (a_writes == 3) a3_cyc = cyc;
        check("wr_a_while_full", 32'(bus.full_a), 0);
        if (exp_a.size() == 0) check("wr_a_unexpected", 1, 0);
        else begin
          mon_row = exp_a.pop_front();
          check("row_a", 32'(bus.row_out), 32'(mon_row));
        end
      end
      if (bus.wr_b) begin
        if (b_writes == 0) first_b_cyc = cyc;
        b_writes++;
        check("wr_b_while_full", 32'(bus.full_b), 0);
        if (exp_b.size() == 0) check("wr_b_unexpected", 1, 0);
        else begin
          mon_row = exp_b.pop_front();
          check("row_b", 32'(bus.row_out), 32'(mon_row));
        end
      end
      if (bus.rd_in) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("rd_after_empty", 32'(prev_empty), 0);
        if (gap_armed && gap_fall_cyc >= 0) begin
          check("rd_resume_lat", cyc - gap_fall_cyc, 1);
          gap_armed = 1'b0;
        end
      end
      if (gap_armed && gap_fall_cyc < 0 && prev_empty && !bus.in_empty) gap_fall_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_de = exp_done.pop_front();
          check("run_count", 32'(bus.run_count), mon_de.runs);
          if (mon_de.zero) check("zero_done_lat", cyc - start_cyc, 2);
          else             check("wr_to_done", cyc - last_wr_cyc, 1);
        end
      end
    end
    prev_empty = bus.in_empty;
  end

  task automatic prepare(input int n, input int col, input int nq, input int ne);
    for (int i = 0; i < n; i++) begin
      row_t r;
      r = mkrow(kv[i], i, col);
      if (i < nq) in_q.push_back(r);
      else        pend_q.push_back(r);
      if (i < ne) begin
        if (dv[i]) exp_b.push_back(r);
        else       exp_a.push_back(r);
      end
    end
    a_writes = 0; b_writes = 0; rd_cnt = 0;
    first_rd_cyc = -1; first_b_cyc = -1; a3_cyc = -1;
  endtask

  task automatic start_pass(input int rc, input int col, input int runs, input bit zero, input bit want_done);
    done_exp_t de;
    de.runs = runs;
    de.zero = zero;
    if (want_done) exp_done.push_back(de);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.row_count = 16'(rc);
    bus.sort_num  = 2'(col);
    start_cyc     = cyc;
    check("busy_before_start", 32'(bus.busy), 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 1);
  endtask

  task automatic wait_done(input string name);
    int d0;
    int t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_cnt == d0) check({name, "_done_timeout"}, 0, 1);
    else begin
      check({name, "_busy_fall"}, 32'(bus.busy), 0);
      check({name, "_done_pulse"}, 32'(bus.done), 0);
    end
    check({name, "_drain_a"}, exp_a.size(), 0);
    check({name, "_drain_b"}, exp_b.size(), 0);
  endtask

  task automatic wait_writes(input string name, input int na, input int nt);
    int t;
    t = 0;
    while ((a_writes < na || a_writes + b_writes < nt) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check({name, "_write_timeout"}, 0, 1);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.row_count = '0;
    bus.sort_num  = '0;
    bus.row_in    = '0;
    bus.in_empty  = 1'b1;
    bus.full_a    = 1'b0;
    bus.full_b    = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_in", 32'(bus.rd_in), 0);
    check("rst_wr_a", 32'(bus.wr_a), 0);
    check("rst_wr_b", 32'(bus.wr_b), 0);
    check("rst_row_out", 32'(bus.row_out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_run_count", 32'(bus.run_count), 0);
    rst = 1'b0;

    // keys 3,5,5,2,7,1: A gets 3,5,5,1; B gets 2,7
    kv = '{8'd3, 8'd5, 8'd5, 8'd2, 8'd7, 8'd1, 8'd0, 8'd0};
    dv = '{0, 0, 0, 1, 1, 0, 0, 0};
    prepare(6, 0, 6, 6);
    start_pass(6, 0, er(3), 1'b0, 1'b1);
    wait_done("basic");
    check("start_to_rd", first_rd_cyc - start_cyc, 2);
    check("basic_rd_count", rd_cnt, 6);

    // same stream, FIFO B full for 10 cycles at its first write
    prepare(6, 0, 6, 6);
    bus.full_b = 1'b1;
    start_pass(6, 0, er(3), 1'b0, 1'b1);
    wait_writes("stall", 3, 0);
    repeat (13) @(posedge clk);
    #1;
    bus.full_b = 1'b0;
    wait_done("stall");
    check("stall_delay", first_b_cyc - a3_cyc, 14);

    // empty pass
    prepare(0, 0, 0, 0);
    start_pass(0, 0, 0, 1'b1, 1'b1);
    wait_done("zero");
    check("zero_rd_count", rd_cnt, 0);
    check("zero_wr_count", a_writes + b_writes, 0);

    // key column 1, input FIFO runs dry after two rows
    kv = '{8'd8, 8'd6, 8'd6, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    dv = '{0, 1, 1, 1, 0, 0, 0, 0};
    prepare(4, 1, 2, 4);
    start_pass(4, 1, er(2), 1'b0, 1'b1);
    wait_writes("gap", 0, 2);
    gap_fall_cyc = -1;
    gap_armed    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    while (pend_q.size() > 0) in_q.push_back(pend_q.pop_front());
    wait_done("gap");
    check("gap_resume_seen", 32'(gap_armed), 0);

    // out-of-range key column: every key is zero, one run into A
    kv = '{8'd9, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    dv = '{0, 0, 0, 0, 0, 0, 0, 0};
    prepare(3, 3, 3, 3);
    start_pass(3, 3, er(1), 1'b0, 1'b1);
    wait_done("col_oob");

    // reset while row 3 sits in WRITE
    kv = '{8'd3, 8'd5, 8'd5, 8'd2, 8'd7, 8'd1, 8'd0, 8'd0};
    dv = '{0, 0, 0, 1, 1, 0, 0, 0};
    prepare(6, 0, 6, 2);
    start_pass(6, 0, 0, 1'b0, 1'b0);
    wait_writes("abort", 2, 0);
    bus.full_a = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_rd_in", 32'(bus.rd_in), 0);
    check("abort_wr_a", 32'(bus.wr_a), 0);
    check("abort_wr_b", 32'(bus.wr_b), 0);
    check("abort_row_out", 32'(bus.row_out), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_run_count", 32'(bus.run_count), 0);
    rst        = 1'b0;
    bus.full_a = 1'b0;
    in_q.delete();
    check("abort_drain_a", exp_a.size(), 0);

    kv = '{8'd4, 8'd2, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    dv = '{0, 1, 1, 0, 0, 0, 0, 0};
    prepare(3, 0, 3, 3);
    start_pass(3, 0, er(2), 1'b0, 1'b1);
    wait_done("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
